// File: rtl/axi_copy_pkg.sv
// Shared widths, state encoding and AXI constants for the AXI copy engine.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

package axi_copy_pkg;
  localparam int ID_W    = `AXI_ID_BITS;
  localparam int ADDR_W  = `AXI_ADDR_BITS;
  localparam int LEN_W   = `AXI_LEN_BITS;
  localparam int SIZE_W  = `AXI_SIZE_BITS;
  localparam int DATA_W  = `AXI_DATA_BITS;
  localparam int STRB_W  = `AXI_STRB_BITS;
  localparam int BEATS_W = LEN_W + 1;

  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {IDLE, CALC, AR, R, AW, W, B, DONE} state_t;
endpackage

// File: rtl/axi_copy_burst_calc.sv
// Beats for the next chunk: limited by words left, MAX_BEATS and the 4KB
// page of both the source and the destination pointer.
module axi_copy_burst_calc
  import axi_copy_pkg::*;
#(
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 16
) (
  input  logic [CNT_W-1:0]   remaining,
  input  logic [ADDR_W-1:0]  src,
  input  logic [ADDR_W-1:0]  dst,
  output logic [BEATS_W-1:0] beats
);
  logic [10:0] src_room;
  logic [10:0] dst_room;
  logic [31:0] lim;
  logic        unused_ok;

  // words left before the next 4KB boundary, 1..1024
  assign src_room = 11'd1024 - {1'b0, src[11:2]};
  assign dst_room = 11'd1024 - {1'b0, dst[11:2]};

  always_comb begin
    lim = (32'(remaining) < 32'(MAX_BEATS)) ? 32'(remaining) : 32'(MAX_BEATS);
    if (32'(src_room) < lim) lim = 32'(src_room);
    if (32'(dst_room) < lim) lim = 32'(dst_room);
    beats = lim[BEATS_W-1:0];
  end

  assign unused_ok = ^{src[ADDR_W-1:12], src[1:0], dst[ADDR_W-1:12], dst[1:0],
                       lim[31:BEATS_W]};
endmodule

// File: rtl/axi_copy_master.sv
// AXI DMA copy engine: read burst into a word buffer, then write it back out.
// state | meaning
// IDLE  | waiting for start
// CALC  | size the next chunk
// AR    | read address offered
// R     | collecting read beats into the buffer
// AW    | write address offered
// W     | streaming the buffer out
// B     | waiting for write response, advance pointers
// DONE  | one-cycle completion pulse
module axi_copy_master
  import axi_copy_pkg::*;
#(
  parameter int               MAX_BEATS = 16,
  parameter int               CNT_W     = 16,
  parameter logic [ID_W-1:0]  MST_ID    = '0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [ADDR_W-1:0]  src_addr,
  input  logic [ADDR_W-1:0]  dst_addr,
  input  logic [CNT_W-1:0]   word_cnt,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [ID_W-1:0]    ARID,
  output logic [ADDR_W-1:0]  ARADDR,
  output logic [LEN_W-1:0]   ARLEN,
  output logic [SIZE_W-1:0]  ARSIZE,
  output logic [1:0]         ARBURST,
  output logic               ARVALID,
  input  logic               ARREADY,
  input  logic [ID_W-1:0]    RID,
  input  logic [DATA_W-1:0]  RDATA,
  input  logic [1:0]         RRESP,
  input  logic               RLAST,
  input  logic               RVALID,
  output logic               RREADY,
  output logic [ID_W-1:0]    AWID,
  output logic [ADDR_W-1:0]  AWADDR,
  output logic [LEN_W-1:0]   AWLEN,
  output logic [SIZE_W-1:0]  AWSIZE,
  output logic [1:0]         AWBURST,
  output logic               AWVALID,
  input  logic               AWREADY,
  output logic [DATA_W-1:0]  WDATA,
  output logic [STRB_W-1:0]  WSTRB,
  output logic               WLAST,
  output logic               WVALID,
  input  logic               WREADY,
  input  logic [ID_W-1:0]    BID,
  input  logic [1:0]         BRESP,
  input  logic               BVALID,
  output logic               BREADY
);
  state_t               state, next;
  logic [ADDR_W-1:0]    src_ptr, dst_ptr;
  logic [CNT_W-1:0]     remaining;
  logic [LEN_W-1:0]     len_q, idx;
  logic [BEATS_W-1:0]   beats, burst_beats;
  logic [DATA_W-1:0]    wbuf [MAX_BEATS];
  logic                 err_q, last_beat, r_hs, w_hs, b_hs;
  logic                 unused_ok;

  axi_copy_burst_calc #(.MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) u_calc (
    .remaining (remaining),
    .src       (src_ptr),
    .dst       (dst_ptr),
    .beats     (beats)
  );

  assign burst_beats = BEATS_W'(len_q) + 1'b1;
  assign last_beat   = (idx == len_q);
  assign r_hs        = RVALID & RREADY;
  assign w_hs        = WVALID & WREADY;
  assign b_hs        = BVALID & BREADY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      len_q     <= '0;
      idx       <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= next;
      case (state)
        IDLE: if (start) begin
          src_ptr   <= src_addr;
          dst_ptr   <= dst_addr;
          remaining <= word_cnt;
          err_q     <= 1'b0;
        end
        CALC: begin
          len_q <= LEN_W'(beats - 1'b1);
          idx   <= '0;
        end
        R: if (r_hs) begin
          if (RRESP != RESP_OKAY) err_q <= 1'b1;
          idx <= last_beat ? '0 : idx + 1'b1;
        end
        W: if (w_hs) idx <= idx + 1'b1;
        B: if (b_hs) begin
          if (BRESP != RESP_OKAY) err_q <= 1'b1;
          src_ptr   <= src_ptr + ADDR_W'({burst_beats, 2'b00});
          dst_ptr   <= dst_ptr + ADDR_W'({burst_beats, 2'b00});
          remaining <= remaining - CNT_W'(burst_beats);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (state == R && r_hs) wbuf[idx] <= RDATA;
  end

  // the beat count alone ends the R phase; RLAST is not trusted
  always_comb begin
    next = state;
    case (state)
      IDLE: if (start) next = (word_cnt == '0) ? DONE : CALC;
      CALC: next = AR;
      AR:   if (ARREADY) next = R;
      R:    if (r_hs && last_beat) next = AW;
      AW:   if (AWREADY) next = W;
      W:    if (w_hs && last_beat) next = B;
      B:    if (b_hs) next = (remaining == CNT_W'(burst_beats)) ? DONE : CALC;
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    ARVALID = 1'b0;
    RREADY  = 1'b0;
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    BREADY  = 1'b0;
    done    = 1'b0;
    case (state)
      AR:   ARVALID = 1'b1;
      R:    RREADY  = 1'b1;
      AW:   AWVALID = 1'b1;
      W:    WVALID  = 1'b1;
      B:    BREADY  = 1'b1;
      DONE: done    = 1'b1;
      default: ;
    endcase
    busy = (state != IDLE) && (state != DONE);
  end

  assign ARID    = MST_ID;
  assign AWID    = MST_ID;
  assign ARSIZE  = SIZE_WORD;
  assign AWSIZE  = SIZE_WORD;
  assign ARBURST = BURST_INCR;
  assign AWBURST = BURST_INCR;
  assign WSTRB   = '1;
  assign ARADDR  = src_ptr;
  assign AWADDR  = dst_ptr;
  assign ARLEN   = len_q;
  assign AWLEN   = len_q;
  assign WDATA   = wbuf[idx];
  assign WLAST   = (state == W) && last_beat;
  assign err     = err_q;

  assign unused_ok = ^{RID, BID, RLAST};
endmodule

// File: tb/tb_axi_copy_master.sv
// Directed bench for axi_copy_master with a behavioural AXI memory slave.
module tb_axi_copy_master;
  import axi_copy_pkg::*;

  localparam int CNT_W = 16;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic              start, busy, done, err;
  logic [ADDR_W-1:0] src_addr, dst_addr;
  logic [CNT_W-1:0]  word_cnt;
  logic [ID_W-1:0]   ARID, AWID, RID, BID;
  logic [ADDR_W-1:0] ARADDR, AWADDR;
  logic [LEN_W-1:0]  ARLEN, AWLEN;
  logic [SIZE_W-1:0] ARSIZE, AWSIZE;
  logic [1:0]        ARBURST, AWBURST, RRESP, BRESP;
  logic              ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic              AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic [DATA_W-1:0] RDATA, WDATA;
  logic [STRB_W-1:0] WSTRB;

  axi_copy_master #(.MAX_BEATS(16), .CNT_W(CNT_W), .MST_ID('0)) dut (
    .CLK(CLK), .RST(RST), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .word_cnt(word_cnt), .busy(busy), .done(done), .err(err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // slave model state and traffic logs
  logic [DATA_W-1:0] mem [4096];
  bit                stall_en = 1'b0;
  int                err_burst = -1;
  int                proto_viol = 0, done_n = 0, ar_n = 0, aw_n = 0, b_n = 0;
  logic [ADDR_W-1:0] ar_addr_log [256], aw_addr_log [256];
  logic [LEN_W-1:0]  ar_len_log [256], aw_len_log [256];
  logic              r_act, w_act, b_pend;
  logic [ADDR_W-1:0] r_addr, w_addr, ar_h_addr, aw_h_addr;
  logic [LEN_W-1:0]  r_left, w_left, ar_h_len, aw_h_len;
  logic              ar_hold, aw_hold, w_hold, w_h_last;
  logic [DATA_W-1:0] w_h_data;

  assign RID = '0;
  assign BID = '0;

  function automatic logic [31:0] pat(input int i);
    return 32'(i) * 32'h9E37_79B1 + 32'h1357_9BDF;
  endfunction

  function automatic bit go();
    return !stall_en || ($urandom_range(0, 3) != 0);
  endfunction

  always @(posedge CLK) begin
    int v;
    v = 0;
    if (done) done_n <= done_n + 1;
    if (RST) begin
      ARREADY <= 1'b0; AWREADY <= 1'b0; WREADY <= 1'b0;
      RVALID <= 1'b0; RLAST <= 1'b0; RDATA <= '0; RRESP <= '0;
      BVALID <= 1'b0; BRESP <= '0;
      r_act <= 1'b0; w_act <= 1'b0; b_pend <= 1'b0; b_n <= 0;
      ar_hold <= 1'b0; aw_hold <= 1'b0; w_hold <= 1'b0;
      for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
    end else begin
      if (ar_hold && (!ARVALID || ARADDR != ar_h_addr || ARLEN != ar_h_len)) v++;
      if (aw_hold && (!AWVALID || AWADDR != aw_h_addr || AWLEN != aw_h_len)) v++;
      if (w_hold && (!WVALID || WDATA != w_h_data || WLAST != w_h_last)) v++;
      if (ARVALID && (ARSIZE != 3'b010 || ARBURST != 2'b01 || ARID != '0)) v++;
      if (AWVALID && (AWSIZE != 3'b010 || AWBURST != 2'b01 || AWID != '0)) v++;
      if (WVALID && WSTRB != 4'hF) v++;
      ar_hold <= ARVALID && !ARREADY; ar_h_addr <= ARADDR; ar_h_len <= ARLEN;
      aw_hold <= AWVALID && !AWREADY; aw_h_addr <= AWADDR; aw_h_len <= AWLEN;
      w_hold  <= WVALID && !WREADY;   w_h_data  <= WDATA;  w_h_last <= WLAST;
      ARREADY <= go(); AWREADY <= go(); WREADY <= go();

      if (ARVALID && ARREADY) begin
        if (r_act) v++;
        ar_addr_log[ar_n] <= ARADDR; ar_len_log[ar_n] <= ARLEN; ar_n <= ar_n + 1;
        r_act <= 1'b1; r_addr <= ARADDR; r_left <= ARLEN;
      end
      if (RVALID && RREADY) begin
        RVALID <= 1'b0;
        if (RLAST) r_act <= 1'b0;
        else begin r_addr <= r_addr + 32'd4; r_left <= r_left - 1'b1; end
      end else if (r_act && !RVALID && go()) begin
        RVALID <= 1'b1; RDATA <= mem[r_addr[13:2]]; RLAST <= (r_left == '0); RRESP <= 2'b00;
      end

      if (AWVALID && AWREADY) begin
        if (w_act || b_pend) v++;
        aw_addr_log[aw_n] <= AWADDR; aw_len_log[aw_n] <= AWLEN; aw_n <= aw_n + 1;
        w_act <= 1'b1; w_addr <= AWADDR; w_left <= AWLEN;
      end
      if (WVALID && WREADY) begin
        if (!w_act) v++;  // write data ahead of its address
        else begin
          mem[w_addr[13:2]] <= WDATA;
          w_addr <= w_addr + 32'd4;
          if (WLAST != (w_left == '0)) v++;
          if (w_left == '0) begin w_act <= 1'b0; b_pend <= 1'b1; end
          else w_left <= w_left - 1'b1;
        end
      end
      if (BVALID && BREADY) begin
        BVALID <= 1'b0; b_pend <= 1'b0; b_n <= b_n + 1;
      end else if (b_pend && !BVALID && go()) begin
        BVALID <= 1'b1; BRESP <= (b_n == err_burst) ? 2'b10 : 2'b00;
      end
      proto_viol <= proto_viol + v;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); @(negedge CLK); RST = 1'b0;
  endtask

  task automatic start_job(input logic [31:0] s, input logic [31:0] d, input int c);
    @(negedge CLK);
    src_addr = s; dst_addr = d; word_cnt = CNT_W'(c); start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 4000) begin @(negedge CLK); lat++; end
  endtask

  task automatic check_data(input string name, input logic [31:0] s, input logic [31:0] d,
                            input int c);
    int bad;
    bad = 0;
    for (int k = 0; k < c; k++)
      if (mem[int'(d[13:2]) + k] !== pat(int'(s[13:2]) + k)) bad++;
    check(name, 64'(bad), 64'd0);
  endtask

  typedef struct {
    logic [31:0]      src;
    logic [31:0]      dst;
    int               cnt;
    bit               stall;
    int               err_burst;
    int               nb;
    logic [2:0][31:0] araddr;
    logic [2:0][3:0]  arlen;
    bit               exp_err;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] s, input logic [31:0] d, input int c,
                              input bit st, input int eb, input int nb,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [3:0] l0,
                              input logic [3:0] l1, input logic [3:0] l2, input bit e);
    vec_t v;
    v.src = s; v.dst = d; v.cnt = c; v.stall = st; v.err_burst = eb; v.nb = nb;
    v.araddr[0] = a0; v.araddr[1] = a1; v.araddr[2] = a2;
    v.arlen[0] = l0; v.arlen[1] = l1; v.arlen[2] = l2; v.exp_err = e;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [8];
    int   ar0, aw0, d0, lat, found;
    logic [31:0] exp_aw;

    vt[0] = mk(32'h0000, 32'h1000,  8, 0, -1, 1, 32'h0000, 32'h0,    32'h0,    4'd7,  4'd0,  4'd0, 0);
    vt[1] = mk(32'h2000, 32'h3000, 40, 0, -1, 3, 32'h2000, 32'h2040, 32'h2080, 4'd15, 4'd15, 4'd7, 0);
    vt[2] = mk(32'h0FF8, 32'h1800,  4, 0, -1, 2, 32'h0FF8, 32'h1000, 32'h0,    4'd1,  4'd1,  4'd0, 0);
    vt[3] = mk(32'h0100, 32'h1FF0,  8, 0, -1, 2, 32'h0100, 32'h0110, 32'h0,    4'd3,  4'd3,  4'd0, 0);
    vt[4] = mk(32'h0400, 32'h2400, 20, 1, -1, 2, 32'h0400, 32'h0440, 32'h0,    4'd15, 4'd3,  4'd0, 0);
    vt[5] = mk(32'h0500, 32'h2500,  0, 0, -1, 0, 32'h0,    32'h0,    32'h0,    4'd0,  4'd0,  4'd0, 0);
    vt[6] = mk(32'h3000, 32'h3100,  1, 0, -1, 1, 32'h3000, 32'h0,    32'h0,    4'd0,  4'd0,  4'd0, 0);
    vt[7] = mk(32'h0800, 32'h2800, 40, 1,  1, 3, 32'h0800, 32'h0840, 32'h0880, 4'd15, 4'd15, 4'd7, 1);

    RST = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; word_cnt = '0;
    repeat (3) @(negedge CLK);
    check("rst_ctrl", 64'({ARVALID, RREADY, AWVALID, WVALID, BREADY, busy, done, err}), 64'd0);
    check("rst_ar", 64'({ARADDR, ARLEN}), 64'd0);
    check("rst_aw", 64'({AWADDR, AWLEN}), 64'd0);

    for (int t = 0; t < 8; t++) begin
      do_reset();
      stall_en  = vt[t].stall;
      err_burst = vt[t].err_burst;
      ar0 = ar_n; aw0 = aw_n; d0 = done_n;
      start_job(vt[t].src, vt[t].dst, vt[t].cnt);
      check($sformatf("v%0d_busy", t), 64'(busy), 64'(vt[t].cnt != 0));
      wait_done(lat);
      check($sformatf("v%0d_done_seen", t), 64'(done), 64'd1);
      if (vt[t].cnt == 0) check($sformatf("v%0d_zero_lat", t), 64'(lat), 64'd1);
      check($sformatf("v%0d_err", t), 64'(err), 64'(vt[t].exp_err));
      repeat (4) @(negedge CLK);
      check($sformatf("v%0d_done_cnt", t), 64'(done_n - d0), 64'd1);
      check($sformatf("v%0d_idle", t), 64'({busy, done}), 64'd0);
      check($sformatf("v%0d_ar_cnt", t), 64'(ar_n - ar0), 64'(vt[t].nb));
      check($sformatf("v%0d_aw_cnt", t), 64'(aw_n - aw0), 64'(vt[t].nb));
      for (int i = 0; i < vt[t].nb; i++) begin
        exp_aw = vt[t].dst + (vt[t].araddr[i] - vt[t].src);
        check($sformatf("v%0d_araddr%0d", t, i), 64'(ar_addr_log[ar0 + i]), 64'(vt[t].araddr[i]));
        check($sformatf("v%0d_arlen%0d", t, i), 64'(ar_len_log[ar0 + i]), 64'(vt[t].arlen[i]));
        check($sformatf("v%0d_awaddr%0d", t, i), 64'(aw_addr_log[aw0 + i]), 64'(exp_aw));
        check($sformatf("v%0d_awlen%0d", t, i), 64'(aw_len_log[aw0 + i]), 64'(vt[t].arlen[i]));
      end
      check_data($sformatf("v%0d_data", t), vt[t].src, vt[t].dst, vt[t].cnt);
      check($sformatf("v%0d_proto", t), 64'(proto_viol), 64'd0);
    end

    // err left set by the last vector; the next accepted start clears it,
    // and a start pulse while busy must be ignored
    stall_en = 1'b0; err_burst = -1;
    ar0 = ar_n; d0 = done_n;
    check("err_sticky", 64'(err), 64'd1);
    start_job(32'h0000, 32'h3800, 4);
    check("err_cleared", 64'(err), 64'd0);
    src_addr = 32'h0200; dst_addr = 32'h3A00; word_cnt = CNT_W'(40); start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_done(lat);
    check("busy_start_done", 64'(done), 64'd1);
    repeat (4) @(negedge CLK);
    check("busy_start_ar_cnt", 64'(ar_n - ar0), 64'd1);
    check("busy_start_araddr", 64'(ar_addr_log[ar0]), 64'h0);
    check("busy_start_arlen", 64'(ar_len_log[ar0]), 64'd3);
    check("busy_start_done_cnt", 64'(done_n - d0), 64'd1);
    check("busy_start_err", 64'(err), 64'd0);
    check_data("busy_start_data", 32'h0000, 32'h3800, 4);

    // reset in the middle of a read burst
    start_job(32'h0000, 32'h3400, 16);
    found = 0;
    for (int k = 0; k < 50 && found == 0; k++) begin
      if (RREADY && RVALID) found = 1;
      else @(negedge CLK);
    end
    check("midr_reached", 64'(found), 64'd1);
    RST = 1'b1;
    @(negedge CLK);
    check("midr_ctrl", 64'({ARVALID, RREADY, AWVALID, WVALID, BREADY, busy, done, err}), 64'd0);
    check("midr_ar", 64'({ARADDR, ARLEN}), 64'd0);
    check("midr_aw", 64'({AWADDR, AWLEN}), 64'd0);
    RST = 1'b0;
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
